counter_gen2: RTL
=================

COUNTER_GEN2 -- requirements
Module: counter_gen2

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter STEP, default 3: increment applied in mode 010, legal range 1..2^WIDTH-1.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset; asynchronous, active-low.
REQ-005 ENB  input  1  count enable.
REQ-006 CI  input  1  cascade carry-in; ties to the RCO of the previous stage, 1 when standalone.
REQ-007 MODO  input  3  operating mode, encoded per REQ-013.
REQ-008 D  input  WIDTH  parallel load value.
REQ-009 LIMIT  input  WIDTH  terminal value for the modulo modes.
REQ-010 Q  output  WIDTH  registered count.
REQ-011 RCO  output  1  combinational ripple carry/borrow out, for cascading.
REQ-012 Paridad  output  1 registered even parity of Q; OVF output 1 registered sticky wrap flag.

Function
REQ-013 MODO decode: 000 = up +1; 001 = down -1; 010 = up +STEP; 011 = load D; 100 = up modulo LIMIT; 101 = down modulo LIMIT; 110 = hold; 111 = synchronous clear.
REQ-014 Effective cycle: ENB=1 and CI=1. Only an effective cycle changes Q, Paridad or OVF. Modes 011 and 111 also require an effective cycle.
REQ-015 Modes 000, 001 and 010 wrap modulo 2^WIDTH; the carry is discarded.
REQ-016 Mode 100:
- next Q = Q+1 if Q<LIMIT.
- Otherwise next Q = 0. This includes Q>LIMIT.
REQ-017 Mode 101:
- next Q = Q-1 if 0<Q<=LIMIT.
- Otherwise next Q = LIMIT. This covers Q=0 and Q>LIMIT.
REQ-018 LIMIT=0 in modes 100/101: Q is forced to 0 and held there. RCO=1 on every effective cycle.
REQ-019 Terminal conditions, one per mode:
- 000: Q=all-ones.
- 001: Q=0.
- 010: Q+STEP>=2^WIDTH.
- 100: Q>=LIMIT.
- 101: Q=0 or Q>LIMIT.
- 011, 110, 111: none.
REQ-020 RCO = ENB & CI & terminal condition of the current MODO, evaluated on current Q. It is purely combinational, with zero latency.
REQ-021 Paridad SHALL equal the XOR-reduction of Q at all times. It is registered, computed from next Q and updated in the same edge as Q.
REQ-022 OVF SHALL set on any edge where RCO=1. It stays set until cleared by mode 011, mode 111 or reset.
REQ-023 If a load or clear coincides with RCO=1, clearing OVF has priority.
REQ-024 MODO, D and LIMIT SHALL be sampled only at the rising edge of an effective cycle. Changes between edges have no effect on Q.
REQ-025 Latency: Q, Paridad and OVF reflect an effective cycle one clock after the edge that samples it.

Reset
REQ-026 RST_N=0 SHALL immediately force Q=0, Paridad=0 and OVF=0, independent of CLK.
REQ-027 RCO SHALL read 0 while RST_N=0.
REQ-028 First update after release: the first rising edge with RST_N=1 and an effective cycle performs a normal update. No extra cycle is lost.
REQ-029 Reset asserted mid-count SHALL discard the in-progress value. No partial update is permitted.

Verification (WIDTH=4, STEP=3)
REQ-030 Asynchronous reset mid-count:
- Stimulus: count in mode 000 to Q=7, then drop RST_N between clock edges.
- Response: Q=0, Paridad=0 and OVF=0 before the next edge.
REQ-031 Up-count wrap:
- Stimulus: load D=E, then mode 000 for two edges.
- Response: Q=F with RCO=1, then Q=0 with OVF=1 and Paridad=0.
REQ-032 Step-mode wrap:
- Stimulus: Q=D, mode 010.
- Response: RCO=1 before the edge; after the edge Q=0 and OVF=1.
- Stimulus: Q=4, mode 010.
- Response: Q=7, RCO=0 and Paridad=1.
REQ-033 Up-modulo sequence:
- Stimulus: mode 100, LIMIT=5, starting at Q=0.
- Response: Q runs 0,1,2,3,4,5,0. RCO=1 only at Q=5.
- Stimulus: mode 100, LIMIT=5, starting at Q=9.
- Response: Q goes to 0.
REQ-034 Down-modulo reload:
- Stimulus: mode 101, LIMIT=9, Q=C.
- Response: Q=9, then 8.
- Stimulus: mode 101, LIMIT=9, Q=0.
- Response: RCO=1, then Q=9.
REQ-035 Cascade and load/clear priority:
- Stimulus: ENB=1, CI=0 in any mode.
- Response: Q is held and RCO=0.
- Stimulus: mode 011 with OVF=1.
- Response: Q=D and OVF=0.
- Stimulus: mode 111.
- Response: Q=0 and OVF=0.

Source files
------------

// File: rtl/counter_gen2.sv
// Cascadable up/down/step/modulo counter with parallel load, registered parity
// and a sticky wrap flag. RCO is combinational so stages can be chained through CI.
module counter_gen2 #(
    parameter int          WIDTH = 8,
    parameter int unsigned STEP  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic             ci,
    input  logic [2:0]       modo,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             paridad,
    output logic             ovf
);

    typedef enum logic [2:0] {
        MODE_UP     = 3'b000,
        MODE_DOWN   = 3'b001,
        MODE_STEP   = 3'b010,
        MODE_LOAD   = 3'b011,
        MODE_UP_LIM = 3'b100,
        MODE_DN_LIM = 3'b101,
        MODE_HOLD   = 3'b110,
        MODE_CLEAR  = 3'b111
    } mode_t;

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    mode_t            mode;
    logic             effective;
    logic             terminal;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] q_next;
    logic             ovf_next;

    assign mode      = mode_t'(modo);
    assign effective = enb & ci;
    // The extra top bit of the sum is the carry out of a step-mode increment.
    assign step_sum  = {1'b0, q} + {1'b0, STEP_W};

    always_comb begin
        terminal = 1'b0;
        case (mode)
            MODE_UP:     terminal = (q == '1);
            MODE_DOWN:   terminal = (q == '0);
            MODE_STEP:   terminal = step_sum[WIDTH];
            MODE_UP_LIM: terminal = (q >= limit);
            MODE_DN_LIM: terminal = (q == '0) || (q > limit);
            default:     terminal = 1'b0;
        endcase
    end

    // Gating with rst_n keeps RCO low while the stage is held in reset.
    assign rco = rst_n & effective & terminal;

    always_comb begin
        q_next = q;
        if (effective) begin
            case (mode)
                MODE_UP:     q_next = q + 1'b1;
                MODE_DOWN:   q_next = q - 1'b1;
                MODE_STEP:   q_next = step_sum[WIDTH-1:0];
                MODE_LOAD:   q_next = d;
                MODE_UP_LIM: q_next = (q < limit) ? q + 1'b1 : '0;
                MODE_DN_LIM: q_next = ((q != '0) && (q <= limit)) ? q - 1'b1 : limit;
                MODE_HOLD:   q_next = q;
                MODE_CLEAR:  q_next = '0;
                default:     q_next = q;
            endcase
        end
    end

    // Load and clear win over a coincident wrap when deciding the sticky flag.
    always_comb begin
        ovf_next = ovf;
        if (effective && (mode == MODE_LOAD || mode == MODE_CLEAR)) begin
            ovf_next = 1'b0;
        end else if (rco) begin
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            paridad <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            q       <= q_next;
            paridad <= ^q_next;
            ovf     <= ovf_next;
        end
    end

endmodule
